// File: rtl/ring_osc_pkg.sv
// Shared types and defaults for the ring-oscillator measurement sequencer.
package ring_osc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_GATE   = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  localparam int DEF_NUM_RO     = 4;
  localparam int DEF_CNT_W      = 16;
  localparam int DEF_GATE_W     = 16;
  localparam int DEF_SETTLE_CYC = 8;
  localparam int MIN_SETTLE_CYC = 4;

endpackage

// File: rtl/ring_osc_meas_ctrl_sync_edge_det.sv
// Two-flop synchronizer for one asynchronous oscillator output, plus a rising-edge pulse.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/ring_osc_meas_ctrl.sv
// Sequences enable/settle/gate/report over a bank of ring oscillators and counts
// synchronized rising edges of the selected oscillator during the gate window.
module ring_osc_meas_ctrl
  import ring_osc_pkg::*;
#(
  parameter int NUM_RO       = DEF_NUM_RO,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int GATE_W       = DEF_GATE_W,
  parameter int SETTLE_CYC   = DEF_SETTLE_CYC,
  localparam int IDX_W       = (NUM_RO > 1) ? $clog2(NUM_RO) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              sweep,
  input  logic [IDX_W-1:0]  ro_sel,
  input  logic [GATE_W-1:0] gate_len,
  input  logic [NUM_RO-1:0] ro_in,
  output logic [NUM_RO-1:0] ro_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  result,
  output logic [IDX_W-1:0]  result_idx,
  output logic              overflow,
  output logic [1:0]        dbg_state
);

  localparam int SETTLE_EFF = (SETTLE_CYC < MIN_SETTLE_CYC) ? MIN_SETTLE_CYC : SETTLE_CYC;
  localparam int SET_W      = $clog2(SETTLE_EFF + 1);
  localparam int TMR_W      = (GATE_W > SET_W) ? GATE_W : SET_W;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_RO - 1);
  localparam logic [NUM_RO-1:0] ONE_HOT0 = NUM_RO'(1);

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic                sweep_q;
  logic [GATE_W-1:0]   gate_q;
  logic [TMR_W-1:0]    tmr;
  logic [CNT_W-1:0]    cnt;
  logic                ovf;
  logic [NUM_RO-1:0]   rise;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                ovf_nxt;
  logic [IDX_W-1:0]    start_idx;

  for (genvar i = 0; i < NUM_RO; i++) begin : g_sync
    sync_edge_det u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (ro_in[i]),
      .rise (rise[i])
    );
  end

  // Saturating edge count for the current gate cycle; overflow marks a lost edge.
  always_comb begin
    cnt_nxt = cnt;
    ovf_nxt = ovf;
    if (rise[idx]) begin
      if (&cnt) ovf_nxt = 1'b1;
      else      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  always_comb begin
    start_idx = '0;
    if (!sweep) start_idx = (ro_sel > LAST_IDX) ? LAST_IDX : ro_sel;
  end

  // start is a request accepted only in IDLE; busy acts as the not-ready indication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      sweep_q    <= 1'b0;
      gate_q     <= '0;
      tmr        <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
      ro_en      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      result_idx <= '0;
      overflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            sweep_q <= sweep;
            idx     <= start_idx;
            gate_q  <= gate_len;
            tmr     <= TMR_W'(SETTLE_EFF - 1);
            cnt     <= '0;
            ovf     <= 1'b0;
            ro_en   <= ONE_HOT0 << start_idx;
            busy    <= 1'b1;
            state   <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          cnt <= '0;
          ovf <= 1'b0;
          if (tmr == '0) begin
            if (gate_q == '0) begin
              ro_en      <= '0;
              done       <= 1'b1;
              result     <= '0;
              overflow   <= 1'b0;
              result_idx <= idx;
              state      <= ST_REPORT;
            end else begin
              tmr   <= TMR_W'(gate_q - GATE_W'(1));
              state <= ST_GATE;
            end
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        ST_GATE: begin
          cnt <= cnt_nxt;
          ovf <= ovf_nxt;
          if (tmr == '0) begin
            ro_en      <= '0;
            done       <= 1'b1;
            result     <= cnt_nxt;
            overflow   <= ovf_nxt;
            result_idx <= idx;
            state      <= ST_REPORT;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        ST_REPORT: begin
          if (sweep_q && (idx != LAST_IDX)) begin
            idx   <= idx + IDX_W'(1);
            ro_en <= ONE_HOT0 << (idx + IDX_W'(1));
            tmr   <= TMR_W'(SETTLE_EFF - 1);
            cnt   <= '0;
            ovf   <= 1'b0;
            state <= ST_SETTLE;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule
